// File: rtl/ps2_scancode_rx_pkg.sv
// Shared constants and types for the PS/2 scancode receiver.
//   PS2_BREAK / PS2_EXT : prefix bytes of the scancode set 2 protocol
//   FRAME_LEN           : start + 8 data + parity + stop
//   ps2_state_t         : deframing FSM state encoding
//   odd_parity_ok()     : true when data bits plus parity bit hold an odd count of ones
package ps2_scancode_rx_pkg;

   localparam logic [7:0] PS2_BREAK = 8'hF0;
   localparam logic [7:0] PS2_EXT   = 8'hE0;
   localparam int         FRAME_LEN = 11;
   localparam int         DATA_BITS = FRAME_LEN - 3;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DATA   = 2'd1,
      ST_PARITY = 2'd2,
      ST_STOP   = 2'd3
   } ps2_state_t;

   function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
      return ^{data, par};
   endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchronizer plus debounce for a raw PS/2 line.
//   clk      : system clock
//   reset    : synchronous active-low reset
//   line     : raw asynchronous line
//   level    : filtered level; follows the synchronized line only after FILTER
//              consecutive samples disagree with the current level (resets to 1)
//   fall_evt : single-cycle pulse on a filtered 1->0 transition, aligned with level
module ps2_line_filter #(
   parameter int FILTER = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic line,
   output logic level,
   output logic fall_evt
);

   localparam int CW = $clog2(FILTER + 1);

   logic          meta;
   logic          sync;
   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (!reset) begin
         meta     <= 1'b1;
         sync     <= 1'b1;
         level    <= 1'b1;
         cnt      <= '0;
         fall_evt <= 1'b0;
      end else begin
         meta     <= line;
         sync     <= meta;
         fall_evt <= 1'b0;
         if (sync == level) begin
            cnt <= '0;
         end else if (cnt == CW'(FILTER - 1)) begin
            level    <= sync;
            cnt      <= '0;
            fall_evt <= ~sync;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard receiver: deframes 11-bit frames and tracks make/break/extended
// prefixes to hold the make code of the currently pressed key.
//   clk       : system clock
//   reset     : synchronous active-low reset
//   ps2_clk   : raw PS/2 clock line (asynchronous)
//   ps2_data  : raw PS/2 data line (asynchronous)
//   scancode  : make code of the held key, 8'h00 when none
//   rx_byte   : last correctly received byte
//   rx_valid  : one-cycle pulse when rx_byte updates
//   frame_err : one-cycle pulse on parity error, bad stop bit or timeout
//
// state     | meaning
// ST_IDLE   | waiting for a start bit (0) on a ps2_clk falling edge
// ST_DATA   | shifting in 8 data bits, LSB first
// ST_PARITY | capturing the parity bit
// ST_STOP   | checking the stop bit and parity, then back to idle
module ps2_scancode_rx
   import ps2_scancode_rx_pkg::*;
#(
   parameter int FILTER  = 8,
   parameter int TIMEOUT = 100000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] scancode,
   output logic [7:0] rx_byte,
   output logic       rx_valid,
   output logic       frame_err
);

   localparam int TW = $clog2(TIMEOUT + 1);

   logic          clk_level;
   logic          fall_evt;
   logic          bit_evt;
   logic          d_meta;
   logic          d_sync;
   ps2_state_t    state;
   ps2_state_t    state_nxt;
   logic [2:0]    bit_cnt;
   logic [7:0]    shift;
   logic          par_bit;
   logic [TW-1:0] tmo_cnt;
   logic          tmo_hit;
   logic          frame_done;
   logic          frame_good;
   logic          brk_pending;
   logic          ext_pending;

   ps2_line_filter #(.FILTER(FILTER)) u_clk_filter (
      .clk      (clk),
      .reset    (reset),
      .line     (ps2_clk),
      .level    (clk_level),
      .fall_evt (fall_evt)
   );

   // fall_evt and the low filtered level are registered together, so this
   // qualifier only guards against a pulse that does not belong to a real fall.
   assign bit_evt = fall_evt & ~clk_level;

   always_ff @(posedge clk) begin
      if (!reset) begin
         d_meta <= 1'b1;
         d_sync <= 1'b1;
      end else begin
         d_meta <= ps2_data;
         d_sync <= d_meta;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      tmo_hit    = (state != ST_IDLE) && (tmo_cnt == TW'(TIMEOUT - 1));
      frame_done = 1'b0;
      frame_good = 1'b0;
      if (tmo_hit) begin
         // timeout beats a coincident falling edge; that bit is dropped
         state_nxt = ST_IDLE;
      end else if (bit_evt) begin
         case (state)
            ST_IDLE:   if (!d_sync) state_nxt = ST_DATA;
            ST_DATA:   if (bit_cnt == 3'(DATA_BITS - 1)) state_nxt = ST_PARITY;
            ST_PARITY: state_nxt = ST_STOP;
            ST_STOP: begin
               state_nxt  = ST_IDLE;
               frame_done = 1'b1;
               frame_good = d_sync && odd_parity_ok(shift, par_bit);
            end
            default:   state_nxt = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         bit_cnt     <= '0;
         shift       <= '0;
         par_bit     <= 1'b0;
         tmo_cnt     <= '0;
         scancode    <= '0;
         rx_byte     <= '0;
         rx_valid    <= 1'b0;
         frame_err   <= 1'b0;
         brk_pending <= 1'b0;
         ext_pending <= 1'b0;
      end else begin
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;

         if (state == ST_IDLE || tmo_hit || bit_evt) tmo_cnt <= '0;
         else                                         tmo_cnt <= tmo_cnt + 1'b1;

         if (tmo_hit) frame_err <= 1'b1;

         if (bit_evt && !tmo_hit) begin
            case (state)
               ST_IDLE:   bit_cnt <= '0;
               ST_DATA: begin
                  shift   <= {d_sync, shift[7:1]};
                  bit_cnt <= bit_cnt + 1'b1;
               end
               ST_PARITY: par_bit <= d_sync;
               default:   ;
            endcase
         end

         if (frame_done) begin
            if (frame_good) begin
               rx_byte  <= shift;
               rx_valid <= 1'b1;
               if (shift == PS2_EXT) begin
                  ext_pending <= 1'b1;
               end else if (shift == PS2_BREAK) begin
                  brk_pending <= 1'b1;
               end else if (brk_pending) begin
                  // releasing an extended key never clears a plain make code
                  if (shift == scancode && !ext_pending) scancode <= '0;
                  brk_pending <= 1'b0;
                  ext_pending <= 1'b0;
               end else if (ext_pending) begin
                  ext_pending <= 1'b0;
               end else begin
                  scancode <= shift;
               end
            end else begin
               frame_err   <= 1'b1;
               brk_pending <= 1'b0;
               ext_pending <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_ps2_scancode_rx.sv
module tb_ps2_scancode_rx;

   localparam int FILTER  = 8;
   localparam int TIMEOUT = 600;
   localparam int HALF    = 20;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       ps2_clk = 1'b1;
   logic       ps2_data = 1'b1;
   logic [7:0] scancode;
   logic [7:0] rx_byte;
   logic       rx_valid;
   logic       frame_err;

   ps2_scancode_rx #(.FILTER(FILTER), .TIMEOUT(TIMEOUT)) dut (
      .clk       (clk),
      .reset     (reset),
      .ps2_clk   (ps2_clk),
      .ps2_data  (ps2_data),
      .scancode  (scancode),
      .rx_byte   (rx_byte),
      .rx_valid  (rx_valid),
      .frame_err (frame_err)
   );

   always #10 clk = ~clk;

   typedef struct {
      bit         is_err;
      logic [7:0] rxb;
      logic [7:0] sc;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;

   // reference model: keyboard state as seen by a host
   logic [7:0] m_sc  = 8'h00;
   logic [7:0] m_rx  = 8'h00;
   bit         m_brk = 0;
   bit         m_ext = 0;

   task automatic model_frame(input logic [7:0] b, input bit good);
      exp_t e;
      if (good) begin
         m_rx = b;
         if (b == 8'hE0) m_ext = 1;
         else if (b == 8'hF0) m_brk = 1;
         else begin
            if (m_brk) begin
               if (b == m_sc && !m_ext) m_sc = 8'h00;
            end else if (!m_ext) begin
               m_sc = b;
            end
            m_brk = 0;
            m_ext = 0;
         end
      end else begin
         m_brk = 0;
         m_ext = 0;
      end
      e.is_err = !good;
      e.rxb    = m_rx;
      e.sc     = m_sc;
      sb.push_back(e);
   endtask

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (reset) begin
         if (rx_valid && frame_err) begin
            checks++;
            errors++;
            $display("FAIL both_pulses: rx_valid=1 frame_err=1 expected never together");
         end else if (rx_valid || frame_err) begin
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL unexpected_event: rx_valid=%b frame_err=%b rx_byte=%h expected no event",
                        rx_valid, frame_err, rx_byte);
            end else begin
               mon_e = sb.pop_front();
               if (frame_err !== mon_e.is_err || rx_byte !== mon_e.rxb || scancode !== mon_e.sc) begin
                  errors++;
                  $display("FAIL event: got err=%b rx_byte=%h scancode=%h expected err=%b rx_byte=%h scancode=%h",
                           frame_err, rx_byte, scancode, mon_e.is_err, mon_e.rxb, mon_e.sc);
               end
            end
         end
      end
   end

   task automatic ps2_bit(input logic b);
      ps2_data = b;
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
      logic par;
      par = ~(^b) ^ bad_par;
      model_frame(b, !bad_par && !bad_stop);
      ps2_bit(1'b0);
      for (int i = 0; i < 8; i++) ps2_bit(b[i]);
      ps2_bit(par);
      ps2_bit(~bad_stop);
      ps2_data = 1'b1;
      repeat (6 * HALF) @(negedge clk);
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 3000 && sb.size() != 0; i++) @(negedge clk);
      if (sb.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout: %0d events outstanding expected 0", sb.size());
         sb.delete();
      end
   endtask

   task automatic do_reset();
      reset = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      m_sc = 8'h00; m_rx = 8'h00; m_brk = 0; m_ext = 0;
      @(negedge clk);
      chk("reset_scancode", scancode, 8'h00);
      chk("reset_rx_byte", rx_byte, 8'h00);
      chk("reset_rx_valid", {7'd0, rx_valid}, 8'h00);
      chk("reset_frame_err", {7'd0, frame_err}, 8'h00);
   endtask

   initial begin
      logic [7:0] pool [8];
      logic [7:0] b;
      exp_t       e;
      pool = '{8'h15, 8'h2B, 8'h33, 8'h1C, 8'hF0, 8'hF0, 8'hE0, 8'h00};

      do_reset();
      repeat (10000) @(negedge clk);

      send_frame(8'h2B, 0, 0);
      wait_drain();
      chk("single_2b_scancode", scancode, 8'h2B);

      send_frame(8'h15, 0, 0);
      send_frame(8'hF0, 0, 0);
      send_frame(8'h15, 0, 0);
      wait_drain();
      chk("release_scancode", scancode, 8'h00);
      chk("release_rx_byte", rx_byte, 8'h15);

      send_frame(8'h1C, 0, 0);
      send_frame(8'h22, 1, 0);
      wait_drain();
      chk("parity_err_scancode", scancode, 8'h1C);
      chk("parity_err_rx_byte", rx_byte, 8'h1C);

      send_frame(8'h2B, 0, 0);
      send_frame(8'hE0, 0, 0);
      send_frame(8'h15, 0, 0);
      send_frame(8'hF0, 0, 0);
      send_frame(8'h33, 0, 0);
      wait_drain();
      chk("prefix_scancode", scancode, 8'h2B);

      send_frame(8'h4D, 0, 1);
      wait_drain();
      chk("bad_stop_scancode", scancode, 8'h2B);

      // abandoned frame: start + 5 data bits, then silence past the timeout
      ps2_bit(1'b0);
      for (int i = 0; i < 5; i++) ps2_bit(1'($urandom_range(0, 1)));
      ps2_data = 1'b1;
      e.is_err = 1; e.rxb = m_rx; e.sc = m_sc;
      sb.push_back(e);
      repeat (TIMEOUT + 100) @(negedge clk);
      send_frame(8'h33, 0, 0);
      wait_drain();
      chk("after_timeout_rx_byte", rx_byte, 8'h33);
      chk("after_timeout_scancode", scancode, 8'h33);

      // reset in the middle of a frame
      ps2_bit(1'b0);
      ps2_bit(1'b1);
      ps2_bit(1'b0);
      do_reset();
      send_frame(8'h1C, 0, 0);
      wait_drain();
      chk("post_reset_scancode", scancode, 8'h1C);

      for (int n = 0; n < 40; n++) begin
         b = pool[$urandom_range(0, 7)];
         if (b == 8'h00) b = (m_sc == 8'h00) ? 8'h15 : m_sc;
         send_frame(b, $urandom_range(0, 9) == 0, $urandom_range(0, 14) == 0);
      end
      wait_drain();
      chk("random_final_scancode", scancode, m_sc);
      chk("random_final_rx_byte", rx_byte, m_rx);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #(20 * 150000);
      $display("FAIL watchdog: simulation exceeded its time limit");
      $fatal(1);
   end

endmodule

// File: doc/ps2_scancode_rx.md
Name: ps2_scancode_rx

Overview:
PS/2 keyboard receiver that sits directly upstream of the PWM tone generator. It samples the raw ps2_clk/ps2_data lines and deframes 11-bit PS/2 frames. It tracks make/break/extended prefixes and drives a held 8-bit `scancode`, which the PWM stage decodes into a duty value. While a key is held, `scancode` shows its make code; on release of that key it returns to 8'h00.

Parameters:
FILTER, 8, consecutive equal synchronized samples required before the filtered ps2_clk level changes
TIMEOUT, 100000, clk cycles without a ps2_clk falling edge mid-frame before the frame is abandoned (2 ms at 50 MHz)

Ports:
clk  input  1  system clock; the only clock
reset  input  1  synchronous, active-low reset (asserted when 0)
ps2_clk  input  1  raw PS/2 clock line, asynchronous
ps2_data  input  1  raw PS/2 data line, asynchronous
scancode  output  8  held make code of the currently pressed key; 8'h00 when none
rx_byte  output  8  last correctly received raw byte
rx_valid  output  1  1-cycle pulse when rx_byte updates
frame_err  output  1  1-cycle pulse on parity error, bad stop bit, or timeout

Behaviour:
- Reset (reset==0 at a clk edge): scancode=0, rx_byte=0, rx_valid=0, frame_err=0, state=IDLE, bit count=0, brk_pending=0, ext_pending=0, timeout counter=0, filtered clock level=1.
- Line conditioning: both lines pass through 2-FF synchronizers. The filtered clock level changes only after FILTER consecutive equal synchronized samples. fall_evt is a 1-cycle pulse on a filtered 1->0 transition. Data is sampled from the synchronized ps2_data on fall_evt.
- FSM, advancing only on fall_evt:
  - IDLE: data==0 -> DATA with bit count=0; data==1 -> stay in IDLE (no error).
  - DATA: shift the bit into the shift register LSB-first; after the 8th bit -> PARITY.
  - PARITY: store the bit -> STOP.
  - STOP: evaluate the frame -> IDLE.
- Frame check at STOP: stop bit must be 1 and the XOR of the 8 data bits and the parity bit must be 1 (odd parity).
  - On pass: registered outputs update on the clk edge after the STOP fall_evt; rx_byte=data and rx_valid=1 for exactly 1 cycle.
  - On fail: frame_err=1 for 1 cycle; rx_byte, rx_valid and scancode are unchanged; prefix flags are cleared.
- Timeout:
  - In any state other than IDLE, the counter increments each cycle and clears on fall_evt.
  - When it reaches TIMEOUT-1: frame_err pulses, FSM goes to IDLE, partial data is discarded, prefix flags are unchanged.
  - In IDLE the counter is held at 0.
- Byte decoding, applied on valid bytes only:
  - 8'hE0 -> ext_pending=1; scancode unchanged.
  - 8'hF0 -> brk_pending=1; scancode unchanged.
  - Other byte with brk_pending=1 -> if the byte equals scancode and ext_pending=0, scancode=0; otherwise unchanged. Clear both flags.
  - Other byte with ext_pending=1 (no break) -> extended make codes are ignored; scancode unchanged; clear ext_pending.
  - Other byte with no flags set -> scancode=byte. Typematic repeats rewrite the same value.
- Simultaneous events: fall_evt in the same cycle the timeout count is reached -> timeout wins and the bit is discarded.
- Reset mid-frame: everything returns to reset values at once; the next frame must start with a fresh start bit.
- rx_valid and frame_err are never both 1 in the same cycle.

Decomposition:
- Shared package/header holds:
  - PS2_BREAK=8'hF0 and PS2_EXT=8'hE0.
  - FSM state encoding IDLE/DATA/PARITY/STOP as 2-bit constants.
  - Frame length 11.
- One sub-module: ps2_line_filter (2-FF synchronizer plus FILTER-sample debounce, producing the filtered level and fall_evt). It is instantiated for ps2_clk; ps2_data uses only the synchronizer.

Test Plan:
- Reset held 0 for 3 cycles, then released; lines idle high -> all outputs 0, no pulses for 10000 cycles.
- Frame 0x2B (data LSB-first 1,1,0,1,0,1,0,0; parity 1; stop 1), 80 us bit period -> rx_byte=8'h2B, one rx_valid pulse, scancode=8'h2B.
- Sequence 0x15, F0, 0x15 -> scancode goes 8'h15 then 8'h00; three rx_valid pulses; rx_byte ends at 8'h15.
- Frame 0x22 sent with parity 0 (wrong) -> frame_err pulses once, no rx_valid, scancode keeps its previous value.
- Sequence 0x2B, then E0, 0x15, then F0, 0x33 -> scancode stays 8'h2B (extended make ignored, break of a non-held key ignored).
- Stop after 5 data bits for more than TIMEOUT cycles, then send a full 0x33 frame -> one frame_err pulse, then rx_byte=8'h33 and scancode=8'h33.
